// File: rtl/vrased_reset_ctrl.sv
// Merges per-monitor violation requests into the core reset, enforcing a minimum
// pulse width, an armed release window and a sticky cause / saturating event count.
module vrased_reset_ctrl #(
  parameter int          NUM_SRC       = 4,
  parameter int          HOLD_CYCLES   = 16,
  parameter int          ARM_TIMEOUT   = 1024,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        pc,
  input  logic [NUM_SRC-1:0] viol,
  output logic               sys_rst,
  output logic [NUM_SRC-1:0] cause,
  output logic               timeout_flag,
  output logic [CNT_W-1:0]   viol_cnt,
  output logic [1:0]         state_o
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int AW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [AW-1:0] ARM_MAX  = AW'(ARM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t             state;
  logic [HW-1:0]      hold_ctr;
  logic [AW-1:0]      arm_ctr;
  logic [NUM_SRC-1:0] viol_prev;

  logic [NUM_SRC-1:0] rise;
  logic               at_handler;
  logic               fire;
  logic               fire_timeout;

  assign rise       = viol & ~viol_prev;
  assign at_handler = (pc == RESET_HANDLER);
  assign state_o    = state;

  // A trigger either carries the live violation levels or, on ARM timeout, none.
  always_comb begin
    fire         = 1'b0;
    fire_timeout = 1'b0;
    case (state)
      ARM: begin
        if (rise != '0 || (at_handler && viol != '0)) begin
          fire = 1'b1;
        end else if (!at_handler && arm_ctr == ARM_MAX) begin
          fire_timeout = 1'b1;
        end
      end
      RUN:     fire = (viol != '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HOLD;
      hold_ctr     <= HOLD_MAX;
      arm_ctr      <= '0;
      viol_prev    <= '0;
      cause        <= '0;
      timeout_flag <= 1'b0;
      viol_cnt     <= '0;
      sys_rst      <= 1'b1;
    end else begin
      viol_prev <= viol;
      if (fire || fire_timeout) begin
        state        <= HOLD;
        sys_rst      <= 1'b1;
        hold_ctr     <= HOLD_MAX;
        cause        <= fire ? viol : '0;
        timeout_flag <= fire_timeout;
        if (viol_cnt != '1) viol_cnt <= viol_cnt + 1'b1;
      end else begin
        case (state)
          HOLD: begin
            // Only fresh rises extend the pulse; a held level must not deadlock.
            if (rise != '0) begin
              hold_ctr <= HOLD_MAX;
              cause    <= cause | rise;
            end else if (hold_ctr == '0) begin
              state   <= ARM;
              sys_rst <= 1'b0;
              arm_ctr <= '0;
            end else begin
              hold_ctr <= hold_ctr - 1'b1;
            end
          end
          ARM: begin
            if (at_handler) begin
              state <= RUN;
            end else begin
              arm_ctr <= arm_ctr + 1'b1;
            end
          end
          RUN: ;
          default: begin
            state    <= HOLD;
            sys_rst  <= 1'b1;
            hold_ctr <= HOLD_MAX;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Scoreboard bench: a cycle-level reference model pushes expected outputs each
// clock; a negedge monitor pops and compares them against the DUT.
module tb_vrased_reset_ctrl;

  localparam int HOLD_CYCLES = 16;
  localparam int ARM_TIMEOUT = 1024;
  localparam int CNT_MAX     = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic [3:0]  viol = 4'b0000;
  logic        sys_rst;
  logic [3:0]  cause;
  logic        timeout_flag;
  logic [7:0]  viol_cnt;
  logic [1:0]  state_o;

  int checks = 0;
  int passed = 0;

  vrased_reset_ctrl dut (
    .clk(clk), .rst(rst), .pc(pc), .viol(viol),
    .sys_rst(sys_rst), .cause(cause), .timeout_flag(timeout_flag),
    .viol_cnt(viol_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sys_rst;
    logic [3:0] cause;
    logic       to;
    logic [7:0] cnt;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];

  // Reference model in terms of "cycles left in the reset pulse" and "cycles spent armed".
  int         m_mode;       // 0 hold, 1 arm, 2 run
  int         m_hold_left;
  int         m_arm_age;
  logic [3:0] m_last;
  logic [3:0] m_cause;
  logic       m_to;
  int         m_cnt;

  task automatic m_event(input logic [3:0] v, input logic is_to);
    m_mode      = 0;
    m_hold_left = HOLD_CYCLES;
    m_cause     = v;
    m_to        = is_to;
    m_cnt       = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
  endtask

  always @(posedge clk) begin
    logic [3:0] rising;
    exp_t e;
    if (rst) begin
      m_mode = 0; m_hold_left = HOLD_CYCLES; m_arm_age = 0;
      m_last = 4'b0; m_cause = 4'b0; m_to = 1'b0; m_cnt = 0;
    end else begin
      rising = viol & ~m_last;
      if (m_mode == 0) begin
        if (rising != 0) begin
          m_hold_left = HOLD_CYCLES;
          m_cause     = m_cause | rising;
        end else begin
          m_hold_left--;
          if (m_hold_left == 0) begin
            m_mode = 1; m_arm_age = 0;
          end
        end
      end else if (m_mode == 1) begin
        if (rising != 0 || (pc == 16'h0000 && viol != 0)) m_event(viol, 1'b0);
        else if (pc == 16'h0000) m_mode = 2;
        else if (m_arm_age + 1 >= ARM_TIMEOUT) m_event(4'b0, 1'b1);
        else m_arm_age++;
      end else begin
        if (viol != 0) m_event(viol, 1'b0);
      end
      m_last = viol;
    end
    e.sys_rst = (m_mode == 0);
    e.cause   = m_cause;
    e.to      = m_to;
    e.cnt     = 8'(m_cnt);
    e.st      = 2'(m_mode);
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {sys_rst, cause, timeout_flag, viol_cnt, state_o};
      checks++;
      if (a === e) passed++;
      else $display("FAIL outputs t=%0t: got rst=%b cause=%b to=%b cnt=%0d st=%0d, need rst=%b cause=%b to=%b cnt=%0d st=%0d",
                    $time, a.sys_rst, a.cause, a.to, a.cnt, a.st, e.sys_rst, e.cause, e.to, e.cnt, e.st);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, need %0d", name, got, want);
  endtask

  initial begin
    int high_cnt;
    // Reset release and pulse width measurement.
    rst = 1'b1; pc = 16'h0000; viol = 4'b0;
    cyc(3);
    rst = 1'b0;
    high_cnt = 0;
    for (int i = 0; i < 40 && sys_rst === 1'b1; i++) begin
      high_cnt++;
      cyc(1);
    end
    check("reset_pulse_width", high_cnt, HOLD_CYCLES);
    cyc(5);
    $display("txn reset release: pulse %0d cycles", high_cnt);

    // Single violation in RUN, then a second source pulsed mid-HOLD.
    viol = 4'b0001; cyc(1); viol = 4'b0000;
    cyc(10);
    viol = 4'b0100; cyc(1); viol = 4'b0000;
    cyc(25);
    check("cause_merge", int'(cause), 5);
    check("count_one", int'(viol_cnt), 1);
    $display("txn violations 0001,0100: cause=%b cnt=%0d", cause, viol_cnt);

    // ARM timeout with pc away from the handler.
    viol = 4'b0001; cyc(1); viol = 4'b0000;
    pc = 16'h4400;
    cyc(HOLD_CYCLES + ARM_TIMEOUT + 4);
    check("timeout_flag", int'(timeout_flag), 1);
    pc = 16'h0000;
    cyc(25);
    $display("txn arm timeout: to=%b cnt=%0d", timeout_flag, viol_cnt);

    // Level-held violation through HOLD, then drop.
    viol = 4'b0001;
    cyc(40);
    viol = 4'b0000;
    cyc(25);
    $display("txn held level: cnt=%0d state=%0d", viol_cnt, state_o);

    // Back-to-back RUN violations until saturation.
    for (int i = 0; i < 300; i++) begin
      viol = 4'($urandom_range(1, 15)); cyc(1); viol = 4'b0000;
      cyc(19);
    end
    check("count_saturated", int'(viol_cnt), CNT_MAX);
    $display("txn 300 violations: cnt=%0d", viol_cnt);

    // rst mid-HOLD.
    viol = 4'b0010; cyc(1); viol = 4'b0000;
    cyc(5);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("rst_cnt_clear", int'(viol_cnt), 0);
    check("rst_cause_clear", int'(cause), 0);
    check("rst_sys_rst", int'(sys_rst), 1);
    cyc(25);
    $display("txn mid-hold rst: cnt=%0d cause=%b", viol_cnt, cause);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      viol = (r < 6) ? 4'($urandom) : ((r < 10) ? viol : 4'b0000);
      if ($urandom_range(0, 49) == 0) pc = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    viol = 4'b0; rst = 1'b0; pc = 16'h0000;
    cyc(3);
    $display("txn random traffic done: cnt=%0d", viol_cnt);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vrased_reset_ctrl.md
Name: vrased_reset_ctrl

Overview:
- Downstream consumer of the per-monitor violation resets (DMA key-access, stack, atomicity, key-access monitors).
- Merges them into the single system reset that drives the MSP430 core.
- Guarantees a minimum reset pulse width and holds the core in reset while violations keep arriving.
- Arms release only until the core fetches from the reset handler; latches a software-readable violation cause and a saturating violation count.

Parameters:
NUM_SRC, 4, number of monitor violation inputs
HOLD_CYCLES, 16, minimum sys_rst assertion length in cycles (>=2)
ARM_TIMEOUT, 1024, max cycles in ARM waiting for pc == RESET_HANDLER
RESET_HANDLER, 16'h0000, reset handler address
CNT_W, 8, violation counter width

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
pc  input  16  core program counter
viol  input  NUM_SRC  monitor reset requests, level, active-high
sys_rst  output  1  registered reset to core, active-high
cause  output  NUM_SRC  sticky sources of last violation event
timeout_flag  output  1  last event was an ARM timeout
viol_cnt  output  CNT_W  saturating count of trigger events
state_o  output  2  current state: HOLD=0, ARM=1, RUN=2

Behaviour:
- All registers update on posedge clk. rst has priority over everything.
- Reset values: state=HOLD, hold_ctr=HOLD_CYCLES-1, arm_ctr=0, viol_prev=0, cause=0, timeout_flag=0, viol_cnt=0, sys_rst=1.
- Output decode: sys_rst = (state == HOLD), registered. sys_rst is never 0 in HOLD and never 1 in ARM/RUN.
- Edge detect: rise = viol & ~viol_prev; viol_prev <= viol every cycle.

State HOLD:
- hold_ctr decrements each cycle.
- Any rise != 0: hold_ctr <= HOLD_CYCLES-1; cause <= cause | rise; viol_cnt unchanged.
- Level-high viol without a rise does not extend HOLD. This avoids deadlock with monitors that stay asserted until pc reaches the handler.
- hold_ctr == 0 and rise == 0: next state ARM, arm_ctr <= 0.
- With no new rises, HOLD lasts exactly HOLD_CYCLES cycles.

State ARM (sys_rst=0):
- Priority 1: rise != 0, or (pc == RESET_HANDLER and viol != 0) -> trigger(viol).
- Priority 2: pc == RESET_HANDLER and viol == 0 -> RUN.
- Priority 3: arm_ctr == ARM_TIMEOUT-1 -> timeout trigger.
- Otherwise arm_ctr increments.

State RUN (sys_rst=0):
- viol != 0 (level) -> trigger(viol). Otherwise stay.

trigger(v):
- next state HOLD, hold_ctr <= HOLD_CYCLES-1, viol_cnt <= sat_inc(viol_cnt).
- cause <= v, timeout_flag <= 0.

timeout trigger:
- same as trigger(0), but timeout_flag <= 1 and cause <= 0.

Timing and counters:
- Latency: viol asserted in RUN at cycle t -> sys_rst=1 from cycle t+1.
- viol_cnt saturates at 2^CNT_W-1 and never wraps.
- cause and timeout_flag hold their values through ARM/RUN until the next trigger; they are cleared only by rst.
- rst mid-HOLD/ARM: immediate return to reset values, and a fresh HOLD_CYCLES pulse follows.
- Simultaneous rises on several sources: all are captured in cause and counted as one event.

Test Plan:
1. rst high 3 cycles, pc=0x0000, viol=0 -> sys_rst=1 for exactly 16 cycles after rst falls. Then state ARM 1 cycle, then RUN; cause=0, viol_cnt=0.
2. RUN, viol=4'b0001 for 1 cycle at t -> sys_rst=1 cycles t+1..t+16, then ARM; pc=0 -> RUN; cause=4'b0001, viol_cnt=1.
3. HOLD with hold_ctr=5, pulse viol[2] -> HOLD lengthened so sys_rst stays high 16 cycles past the pulse; cause=4'b0101, viol_cnt=1.
4. Release to ARM with pc fixed at 0x4400, viol=0 -> after 1024 ARM cycles state HOLD; timeout_flag=1, cause=0, viol_cnt incremented.
5. viol[0] held high through HOLD with pc=0 -> ARM sees pc==RESET_HANDLER with viol!=0 and returns to HOLD (viol_cnt+1). Drop viol -> next ARM goes to RUN.
6. 300 back-to-back RUN violations -> viol_cnt=255. Then rst mid-HOLD -> viol_cnt=0, cause=0, sys_rst=1, new 16-cycle pulse.
